cic_comp_decim: RTL and testbench

- Compensation FIR that sits directly downstream of cic_filter, on the CIC output clock domain.
- Flattens the CIC sinc passband droop with a fixed 7-tap symmetric FIR and decimates by a further DECIM.
- Time-multiplexed: one multiplier and one pre-adder, so each output costs a short MAC burst.
- Consumes the CIC's 9-bit signed samples; produces same-width samples at 1/DECIM of the input rate.

---
 rtl/cic_comp_decim.sv | 169 ++++++++++++++++
 tb/tb_cic_comp_decim.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_comp_decim.sv
// cic_comp_decim: 7-tap symmetric droop compensator for the CIC output, decimating by DECIM.
// Optional macro CIC_COMP_SAT_EN: clamp the rounded result and expose a sticky sat_o flag.
module cic_comp_decim #(
    parameter int DATA_WIDTH = 9,
    parameter int COEF_WIDTH = 10,
    parameter int COEF_FRAC  = 8,
    parameter int ACC_WIDTH  = 22,
    parameter int DECIM      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ena_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
`ifdef CIC_COMP_SAT_EN
    ,
    output logic                  sat_o
`endif
);
    localparam int PRE_W  = DATA_WIDTH + 1;
    localparam int PROD_W = PRE_W + COEF_WIDTH;
    localparam logic [1:0] LAST_PH = 2'(DECIM - 1);
    localparam logic signed [ACC_WIDTH-1:0] RND_C = ACC_WIDTH'(2 ** (COEF_FRAC - 1));

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, ROUND = 2'd2, OUT = 2'd3} state_t;

    state_t                       state_r, state_nxt_s;
    logic                         ready_r, ready_nxt_s, valid_r;
    logic [DATA_WIDTH-1:0]        data_r;
    logic [DATA_WIDTH-1:0]        taps_r [7];
    logic [1:0]                   phase_r, step_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic                         accept_s, trigger_s;
    logic signed [PRE_W-1:0]      pre_s;
    logic signed [COEF_WIDTH-1:0] coef_s;
    logic signed [PROD_W-1:0]     prod_s;
    logic [DATA_WIDTH-1:0]        red_s;

    function automatic logic signed [PRE_W-1:0] sext(input logic [DATA_WIDTH-1:0] x);
        return {x[DATA_WIDTH-1], x};
    endfunction

    // Only c0..c3 are stored; the symmetric pre-add folds the mirrored taps onto them.
    function automatic logic signed [COEF_WIDTH-1:0] coef_at(input logic [1:0] idx);
        case (idx)
            2'd0:    return COEF_WIDTH'(-32'sd8);
            2'd1:    return COEF_WIDTH'(32'sd0);
            2'd2:    return COEF_WIDTH'(32'sd72);
            2'd3:    return COEF_WIDTH'(32'sd128);
            default: return COEF_WIDTH'(32'sd0);
        endcase
    endfunction

    assign accept_s  = ena_i & ready_r;
    assign trigger_s = accept_s & (phase_r == LAST_PH);

    // Pre-adder operand select for the current MAC step
    always_comb begin
        pre_s = '0;
        case (step_r)
            2'd0:    pre_s = sext(taps_r[0]) + sext(taps_r[6]);
            2'd1:    pre_s = sext(taps_r[1]) + sext(taps_r[5]);
            2'd2:    pre_s = sext(taps_r[2]) + sext(taps_r[4]);
            2'd3:    pre_s = sext(taps_r[3]);
            default: pre_s = '0;
        endcase
    end

    assign coef_s = coef_at(step_r);
    assign prod_s = PROD_W'(pre_s) * PROD_W'(coef_s);

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] MAX_C = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MIN_C = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));
    logic signed [ACC_WIDTH-1:0] shr_s;
    logic                        clamp_s;
    logic                        sat_r;

    assign shr_s = (acc_r + RND_C) >>> COEF_FRAC;

    // Round-half-up result clamped to the output range
    always_comb begin
        red_s   = shr_s[DATA_WIDTH-1:0];
        clamp_s = 1'b0;
        if (shr_s > MAX_C) begin
            red_s   = MAX_C[DATA_WIDTH-1:0];
            clamp_s = 1'b1;
        end else if (shr_s < MIN_C) begin
            red_s   = MIN_C[DATA_WIDTH-1:0];
            clamp_s = 1'b1;
        end else begin
            red_s   = shr_s[DATA_WIDTH-1:0];
            clamp_s = 1'b0;
        end
    end

    // Sticky saturation flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sat_r <= 1'b0;
        end else if ((state_r == ROUND) && clamp_s) begin
            sat_r <= 1'b1;
        end
    end

    assign sat_o = sat_r;
`else
    assign red_s = DATA_WIDTH'((acc_r + RND_C) >>> COEF_FRAC);
`endif

    // Next-state and next-ready decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, OUT: state_nxt_s = trigger_s ? MAC : IDLE;
            MAC:       state_nxt_s = (step_r == 2'd3) ? ROUND : MAC;
            ROUND:     state_nxt_s = OUT;
            default:   state_nxt_s = IDLE;
        endcase
        ready_nxt_s = (state_nxt_s == IDLE) || (state_nxt_s == OUT);
    end

    // State and handshake registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    // Delay line, phase counter, MAC accumulator and output register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 7; i++) taps_r[i] <= '0;
            phase_r <= 2'd0;
            step_r  <= 2'd0;
            acc_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (accept_s) begin
                taps_r[0] <= data_i;
                for (int i = 1; i < 7; i++) taps_r[i] <= taps_r[i-1];
                phase_r <= trigger_s ? 2'd0 : phase_r + 2'd1;
            end
            if (trigger_s) begin
                acc_r  <= '0;
                step_r <= 2'd0;
            end else if (state_r == MAC) begin
                acc_r  <= acc_r + ACC_WIDTH'(prod_s);
                step_r <= step_r + 2'd1;
            end
            if (state_r == ROUND) begin
                data_r  <= red_s;
                valid_r <= 1'b1;
            end
        end
    end

    assign ready_o = ready_r;
    assign valid_o = valid_r;
    assign data_o  = data_r;
endmodule

// File: tb/tb_cic_comp_decim.sv
// Bench for cic_comp_decim: directed vector table, reset/abort sequences and a randomized run
// checked against an arithmetic model of the filter.
module tb_cic_comp_decim;
    localparam int DW    = 9;
    localparam int DECIM = 2;

`ifdef CIC_COMP_SAT_EN
    localparam int DCN3 = -256;
    localparam int DCP3 = 255;
    localparam int OVF  = 255;
`else
    localparam int DCN3 = 248;
    localparam int DCP3 = -249;
    localparam int OVF  = -241;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rdy, vld;
    logic [DW-1:0] dout;
`ifdef CIC_COMP_SAT_EN
    logic          sat;
`endif

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    cic_comp_decim dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .ena_i   (ena),
        .data_i  (din),
        .ready_o (rdy),
        .valid_o (vld),
        .data_o  (dout)
`ifdef CIC_COMP_SAT_EN
        ,
        .sat_o   (sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference model: sample history, phase and busy window, from the filter definition.
    int coef [7] = '{-8, 0, 72, 128, 72, 0, -8};
    int hist [7] = '{0, 0, 0, 0, 0, 0, 0};
    int phase_m = 0;
    int busy_m  = 0;
    typedef struct { int val; int cyc; } pend_t;
    pend_t pend_q [$];
    int    got_q  [$];

    function automatic int ref_out();
        int acc;
        int r;
        acc = 128;
        for (int k = 0; k < 7; k++) acc += coef[k] * hist[k];
        r = (acc >= 0) ? acc / 256 : -((-acc + 255) / 256);
`ifdef CIC_COMP_SAT_EN
        if (r > 255) r = 255;
        if (r < -256) r = -256;
`else
        r = ((r % 512) + 512) % 512;
        if (r > 255) r -= 512;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        bit mrdy;
        if (!rst) begin
            for (int k = 0; k < 7; k++) hist[k] = 0;
            phase_m = 0;
            busy_m  = 0;
            pend_q.delete();
        end else begin
            mrdy = (busy_m == 0);
            check("ready", int'(rdy), int'(mrdy));
            if (busy_m > 0) busy_m--;
            if (ena && mrdy) begin
                for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'($signed(din));
                if (phase_m == DECIM - 1) begin
                    phase_m = 0;
                    busy_m  = 5;
                    pend_q.push_back('{ref_out(), cyc});
                end else begin
                    phase_m++;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        pend_t p;
        if (vld === 1'b1) begin
            got_q.push_back(int'($signed(dout)));
            if (pend_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                p = pend_q.pop_front();
                check("model_data", int'($signed(dout)), p.val);
                check("latency", cyc, p.cyc + 6);
            end
        end
    end

    typedef struct packed {
        logic [9:0][DW-1:0] s;
        logic [4:0][DW-1:0] e;
        logic               sat;
    } rec_t;
    rec_t tbl [5];

    function automatic logic [DW-1:0] w(input int v);
        return v[DW-1:0];
    endfunction

    task automatic set_e(input int r, input int a, input int b, input int c, input int d,
                         input int f, input logic s);
        tbl[r].e[0] = w(a);
        tbl[r].e[1] = w(b);
        tbl[r].e[2] = w(c);
        tbl[r].e[3] = w(d);
        tbl[r].e[4] = w(f);
        tbl[r].sat  = s;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push(input int v);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rdy !== 1'b1) check("ready_timeout", 0, 1);
        ena = 1'b1;
        din = w(v);
        @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic run_rec(input int r, input bit with_reset);
        int n;
        if (with_reset) do_reset(2);
`ifdef CIC_COMP_SAT_EN
        check($sformatf("tbl%0d_sat_start", r), int'(sat), 0);
`endif
        got_q.delete();
        for (int i = 0; i < 10; i++) push(int'($signed(tbl[r].s[i])));
        n = 0;
        while (got_q.size() < 5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("tbl%0d_count", r), got_q.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < got_q.size())
                check($sformatf("tbl%0d_out%0d", r, k), got_q[k], int'($signed(tbl[r].e[k])));
`ifdef CIC_COMP_SAT_EN
        check($sformatf("tbl%0d_sat_end", r), int'(sat), int'(tbl[r].sat));
`endif
    endtask

    initial begin
        for (int r = 0; r < 5; r++) tbl[r] = '0;
        tbl[0].s[1] = w(255);
        set_e(0, -8, 72, 72, -8, 0, 1'b0);
        tbl[1].s[0] = w(255);
        set_e(1, 0, 128, 0, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) tbl[2].s[i] = w(-256);
        set_e(2, 8, -192, DCN3, -256, -256, 1'b1);
        for (int i = 0; i < 10; i++) tbl[3].s[i] = w(255);
        set_e(3, -8, 191, DCP3, 255, 255, 1'b1);
        for (int i = 0; i < 5; i++) tbl[4].s[i] = w(255);
        set_e(4, -8, 191, OVF, 191, -8, 1'b1);

        // Reset held with traffic offered: outputs stay at reset values
        ena = 1'b1;
        din = w(100);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_data", int'(dout), 0);
            check("rst_valid", int'(vld), 0);
            check("rst_ready", int'(rdy), 1);
        end
`ifdef CIC_COMP_SAT_EN
        check("rst_sat", int'(sat), 0);
`endif
        ena = 1'b0;
        din = '0;
        rst = 1'b1;

        run_rec(0, 1'b0);
        for (int r = 1; r < 5; r++) run_rec(r, 1'b1);

        // Reset in the middle of a MAC burst must suppress that output
        do_reset(2);
        push(0);
        push(255);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("abort_no_valid", int'(vld), 0);
        end
        run_rec(0, 1'b0);

        // Randomized traffic, ena often asserted while busy
        do_reset(2);
        for (int i = 0; i < 800; i++) begin
            ena = (i < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
            din = w(int'($urandom_range(0, 511)));
            @(negedge clk);
        end
        ena = 1'b0;
        repeat (12) @(negedge clk);
        check("pending_drained", pend_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
